// File: rtl/rsensor_ctrl_if.sv
// rsensor_ctrl_if: sensor-side and result-side signals of the range sensor controller.
//   in_start    request one measurement
//   in_echo     asynchronous echo from the sensor
//   out_trig    trigger pulse to the sensor
//   out_busy    controller is not idle
//   out_valid   one-cycle pulse when a new result is published
//   out_width   last echo width, all-ones on timeout
//   out_timeout last result was a timeout
interface rsensor_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             in_start;
    logic             in_echo;
    logic             out_trig;
    logic             out_busy;
    logic             out_valid;
    logic [CNT_W-1:0] out_width;
    logic             out_timeout;
    modport master (
        output in_start, in_echo,
        input  out_trig, out_busy, out_valid, out_width, out_timeout
    );
    modport slave (
        input  in_start, in_echo,
        output out_trig, out_busy, out_valid, out_width, out_timeout
    );
endinterface

// File: rtl/rsensor_ctrl.sv
// rsensor_ctrl: ultrasonic range sensor trigger / echo-width measurement controller.
//   in_clk, in_rst  single rising-edge clock, synchronous active-high reset
//   bus (slave)     in_start, in_echo in; out_trig, out_busy, out_valid,
//                   out_width, out_timeout out (all outputs registered)
//   RSENSOR_CTRL_AUTO_EN  when defined, triggers free-run and in_start is ignored
module rsensor_ctrl #(
    parameter int TRIG_CYCLES    = 10,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HOLDOFF_CYCLES = 50,
    parameter int TICK_DIV       = 1,
    parameter int CNT_W          = 16
) (
    input logic           in_clk,
    input logic           in_rst,
    rsensor_ctrl_if.slave bus
);
    localparam int PH_MAX = (TRIG_CYCLES > HOLDOFF_CYCLES) ? TRIG_CYCLES : HOLDOFF_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PS_W   = $clog2(TICK_DIV + 1);
`ifdef RSENSOR_CTRL_AUTO_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_DONE, S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q;
    logic             echo_prev_q;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [PS_W-1:0]  ps_q, ps_d, ps_in;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_in;
    logic [CNT_W-1:0] width_q, width_d;
    logic             tmo_q, tmo_d;
    logic             trig_q, busy_q, valid_q;
    logic             echo_s, rise, expire, tick, go;

    always_comb begin
        echo_s  = sync_q[1];
        rise    = echo_s && !echo_prev_q;
        expire  = to_q == TO_W'(TIMEOUT_CYCLES - 1);
        go      = AUTO || bus.in_start;
        // Outside MEASURE the width step starts from zero, so the cycle that
        // detects the rise is already counted; this cancels the synchronizer
        // delay and makes an E-clock echo measure exactly E.
        ps_in   = (state_q == S_MEAS) ? ps_q : '0;
        cnt_in  = (state_q == S_MEAS) ? cnt_q : '0;
        tick    = ps_in == PS_W'(TICK_DIV - 1);
        state_d = state_q;
        ph_d    = ph_q;
        to_d    = to_q;
        ps_d    = ps_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_TRIG;
                    ph_d    = '0;
                end
            end
            S_TRIG: begin
                ph_d = ph_q + 1'b1;
                if (ph_q == PH_W'(TRIG_CYCLES - 1)) begin
                    state_d = S_WAIT;
                    to_d    = '0;
                end
            end
            S_WAIT, S_MEAS: begin
                to_d  = to_q + 1'b1;
                ps_d  = tick ? '0 : ps_in + 1'b1;
                cnt_d = (tick && cnt_in != '1) ? cnt_in + 1'b1 : cnt_in;
                // An echo fall takes priority over a coincident timeout.
                if (state_q == S_MEAS && !echo_s) begin
                    state_d = S_DONE;
                    width_d = cnt_q;
                    tmo_d   = 1'b0;
                end else if (expire) begin
                    state_d = S_DONE;
                    width_d = '1;
                    tmo_d   = 1'b1;
                end else if (state_q == S_WAIT && rise) begin
                    state_d = S_MEAS;
                end
            end
            S_DONE: begin
                state_d = S_HOLD;
                ph_d    = '0;
            end
            S_HOLD: begin
                ph_d = ph_q + 1'b1;
                if (ph_q == PH_W'(HOLDOFF_CYCLES - 1)) begin
                    state_d = AUTO ? S_TRIG : S_IDLE;
                    ph_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= S_IDLE;
            sync_q      <= '0;
            echo_prev_q <= 1'b0;
            ph_q        <= '0;
            to_q        <= '0;
            ps_q        <= '0;
            cnt_q       <= '0;
            width_q     <= '0;
            tmo_q       <= 1'b0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], bus.in_echo};
            echo_prev_q <= echo_s;
            ph_q        <= ph_d;
            to_q        <= to_d;
            ps_q        <= ps_d;
            cnt_q       <= cnt_d;
            width_q     <= width_d;
            tmo_q       <= tmo_d;
            trig_q      <= state_d == S_TRIG;
            busy_q      <= state_d != S_IDLE;
            valid_q     <= state_d == S_DONE;
        end
    end

    assign bus.out_trig    = trig_q;
    assign bus.out_busy    = busy_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_width   = width_q;
    assign bus.out_timeout = tmo_q;
endmodule

// File: tb/tb_rsensor_ctrl.sv
// tb_rsensor_ctrl: three controllers (default, TICK_DIV=4, CNT_W=4) on shared stimulus, checked against a transaction-level model.
module tb_rsensor_ctrl;
    localparam int T  = 10;
    localparam int TO = 1000;
    localparam int H  = 50;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, echo = 1'b0;
    int   cyc = 0, n_vec = 0, n_err = 0, nv = 0, vc = 0;
    bit   chk_on = 1'b0, old_t = 1'b0, new_t = 1'b0, vt = 1'b0;
    int   m_s = -10000, m_v = -10000;
    int   old_w[3] = '{0, 0, 0};
    int   new_w[3] = '{0, 0, 0};
    int   vw[3] = '{0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rsensor_ctrl_if #(.CNT_W(16)) if0 ();
    rsensor_ctrl_if #(.CNT_W(16)) if1 ();
    rsensor_ctrl_if #(.CNT_W(4))  if2 ();
    assign if0.in_start = start;
    assign if1.in_start = start;
    assign if2.in_start = start;
    assign if0.in_echo  = echo;
    assign if1.in_echo  = echo;
    assign if2.in_echo  = echo;

    rsensor_ctrl u0 (.in_clk(clk), .in_rst(rst), .bus(if0.slave));
    rsensor_ctrl #(.TICK_DIV(4)) u1 (.in_clk(clk), .in_rst(rst), .bus(if1.slave));
    rsensor_ctrl #(.CNT_W(4)) u2 (.in_clk(clk), .in_rst(rst), .bus(if2.slave));

    function automatic int sat(input int x, input int w);
        return (x > (1 << w) - 1) ? (1 << w) - 1 : x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic cmp(input int k, input logic tr, input logic bz, input logic vl,
                       input logic tm, input logic [15:0] w);
        bit nw;
        nw = cyc >= m_v;
        chk($sformatf("trig%0d", k), 32'(tr), 32'(cyc > m_s && cyc <= m_s + T));
        chk($sformatf("busy%0d", k), 32'(bz), 32'(cyc > m_s && cyc <= m_v + H));
        chk($sformatf("valid%0d", k), 32'(vl), 32'(cyc == m_v));
        chk($sformatf("timeout%0d", k), 32'(tm), 32'(nw ? new_t : old_t));
        chk($sformatf("width%0d", k), 32'(w), nw ? new_w[k] : old_w[k]);
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            cmp(0, if0.out_trig, if0.out_busy, if0.out_valid, if0.out_timeout, if0.out_width);
            cmp(1, if1.out_trig, if1.out_busy, if1.out_valid, if1.out_timeout, if1.out_width);
            cmp(2, if2.out_trig, if2.out_busy, if2.out_valid, if2.out_timeout, 16'(if2.out_width));
        end
    end

    always @(posedge clk) begin
        #1;
        if (if0.out_valid === 1'b1) begin
            nv++;
            vc    = cyc;
            vw[0] = int'(if0.out_width);
            vw[1] = int'(if1.out_width);
            vw[2] = int'(if2.out_width);
            vt    = if0.out_timeout;
        end
    end

    // One measurement starting next cycle: in_echo high from trigger-fall
    // offset r_off for e clocks (e<0: stuck high). Returns at the last holdoff cycle.
    task automatic run(input int r_off, input int e, input bit pk, output int s);
        int l, r, v;
        int nw[3];
        bit nt;
        @(negedge clk);
        s = cyc;
        l = s + T;
        r = (e < 0) ? s : l + r_off;
        if (e > 0 && r >= l - 1 && r + e + 2 <= l + TO) begin
            v  = r + e + 3;
            nw = '{sat(e, 16), sat(e / 4, 16), sat(e, 4)};
            nt = 1'b0;
        end else begin
            v  = l + TO + 1;
            nw = '{65535, 65535, 15};
            nt = 1'b1;
        end
        old_w = new_w;
        old_t = new_t;
        new_w = nw;
        new_t = nt;
        m_s   = s;
        m_v   = v;
        start = 1'b1;
        echo  = (e < 0) || (cyc >= r && cyc < r + e);
        while (cyc < v + H) begin
            @(negedge clk);
            start = pk && (cyc == s + 3 || cyc == r + 10 || cyc == v + 5);
            echo  = (e < 0) || (cyc >= r && cyc < r + e);
        end
        echo = 1'b0;
    endtask

    initial begin
        int s, nv0;
        repeat (3) begin
            @(negedge clk);
            echo = ~echo;
        end
        @(negedge clk);
        chk("rst_trig", 32'(if0.out_trig), 0);
        chk("rst_busy", 32'(if0.out_busy), 0);
        chk("rst_valid", 32'(if0.out_valid), 0);
        chk("rst_width", 32'(if0.out_width), 0);
        chk("rst_timeout", 32'(if0.out_timeout), 0);
        rst  = 1'b0;
        echo = 1'b0;
`ifdef RSENSOR_CTRL_AUTO_EN
        begin : auto_blk
            int ts[$];
            bit pt;
            pt = 1'b0;
            for (int i = 0; i < 4000 && nv < 3; i++) begin
                @(negedge clk);
                if (if0.out_trig && !pt) ts.push_back(cyc);
                pt = if0.out_trig;
            end
            chk("auto_results", nv, 3);
            chk("auto_timeout", 32'(vt), 1);
            if (ts.size() >= 3) begin
                chk("auto_gap1", ts[1] - ts[0], T + TO + 1 + H);
                chk("auto_gap2", ts[2] - ts[1], T + TO + 1 + H);
            end else begin
                chk("auto_trigs", ts.size(), 3);
            end
        end
`else
        chk_on = 1'b1;
        repeat (20) @(negedge clk);
        run(30, 200, 1'b0, s);
        chk("pin_norm_lat", vc - s, 243);
        chk("pin_norm_w", vw[0], 200);
        chk("pin_norm_div4", vw[1], 50);
        chk("pin_norm_sat4", vw[2], 15);
        chk("pin_norm_to", 32'(vt), 0);
        run(0, 0, 1'b0, s);
        chk("pin_noecho_lat", vc - s, 1011);
        chk("pin_noecho_w", vw[0], 16'hFFFF);
        chk("pin_noecho_to", 32'(vt), 1);
        run(0, -1, 1'b0, s);
        chk("pin_stuck_to", 32'(vt), 1);
        run(898, 100, 1'b0, s);
        chk("pin_tie_w", vw[0], 100);
        chk("pin_tie_to", 32'(vt), 0);
        run(899, 100, 1'b0, s);
        chk("pin_late_to", 32'(vt), 1);
        run(-1, 20, 1'b0, s);
        chk("pin_early_w", vw[0], 20);
        run(-2, 20, 1'b0, s);
        chk("pin_stale_to", 32'(vt), 1);
        run(30, 200, 1'b1, s);
        run(30, 60, 1'b0, s);
        chk("pin_b2b_lat", vc - s, 103);
        chk("pin_b2b_w", vw[0], 60);
        @(negedge clk);
        s     = cyc;
        start = 1'b1;
        old_w = new_w;
        old_t = new_t;
        m_s   = s;
        m_v   = 1 << 30;
        while (cyc < s + T + 40) begin
            @(negedge clk);
            start = 1'b0;
            echo  = cyc >= s + T + 5;
        end
        rst   = 1'b1;
        nv0   = nv;
        m_s   = -10000;
        m_v   = -10000;
        old_w = '{0, 0, 0};
        new_w = '{0, 0, 0};
        old_t = 1'b0;
        new_t = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        while (cyc < s + T + 105) @(negedge clk);
        echo = 1'b0;
        repeat (200) @(negedge clk);
        chk("midrst_valid", nv - nv0, 0);
        chk("midrst_w", 32'(if0.out_width), 0);
        run(10, 37, 1'b0, s);
        chk("pin_recover_w", vw[0], 37);
        chk("pin_recover_div4", vw[1], 9);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rsensor_ctrl.md
# rsensor_ctrl

Measurement controller for the ultrasonic range sensor (`rsensor`). It issues a fixed-width trigger pulse, synchronizes the asynchronous echo input and measures the echo pulse width in prescaled clock ticks. It also enforces a timeout and a re-trigger holdoff. It sits between the sensor pins and any consumer of raw echo widths, such as a distance converter or a register file.

## Interface
- `TRIG_CYCLES`, 10, trigger pulse width in clocks (≥1)
- `TIMEOUT_CYCLES`, 1000, max clocks from trigger fall to end of echo (≥2)
- `HOLDOFF_CYCLES`, 50, dead time after each result before next trigger (≥1)
- `TICK_DIV`, 1, clocks per width count (≥1)
- `CNT_W`, 16, width of result counter
- `in_clk` in 1 — single clock, all logic rising-edge
- `in_rst` in 1 — reset, synchronous, active-high
- `in_start` in 1 — request one measurement; sampled only in IDLE
- `in_echo` in 1 — asynchronous echo from sensor
- `out_trig` out 1 — trigger to sensor (registered)
- `out_busy` out 1 — high in every state except IDLE
- `out_valid` out 1 — one-cycle pulse: result updated
- `out_width` out CNT_W — last echo width; held between results
- `out_timeout` out 1 — last result was a timeout; updated with `out_valid`

## Operation
- `in_echo` passes through a 2-flop synchronizer; the FSM uses only the synchronized value `echo_s` and its previous value.
- States:
  - **IDLE**: `in_start`=1 → TRIG.
  - **TRIG**: `out_trig`=1 for exactly TRIG_CYCLES cycles → WAIT_ECHO.
  - **WAIT_ECHO**: waits for a rising edge of `echo_s` → MEASURE. An echo already high on entry is stale and does not count; a low then high transition is required.
  - **MEASURE**: `echo_s` low → DONE with the width.
  - **DONE**: 1 cycle; `out_valid`=1 → HOLDOFF.
  - **HOLDOFF**: HOLDOFF_CYCLES cycles → IDLE.
- Timeout counter:
  - Cleared on entry to WAIT_ECHO and not cleared on echo rise.
  - Reaching TIMEOUT_CYCLES in WAIT_ECHO or MEASURE → DONE with `out_timeout`=1 and `out_width`=all-ones.
- Width counter:
  - Prescaler and width are cleared on entry to MEASURE.
  - Width increments once per TICK_DIV cycles that `echo_s` is high in MEASURE.
  - Width saturates at 2^CNT_W−1. A saturated result without timeout has `out_timeout`=0.
- Simultaneous events:
  - Echo fall in the same cycle the timeout expires → the measured width wins, `out_timeout`=0.
  - `in_start` is ignored outside IDLE. It is not queued.
- `in_rst` at any point: FSM → IDLE, outputs → reset values, synchronizer and counters cleared. An in-flight echo is discarded.

## Timing
- Reset values: `out_trig`=0, `out_busy`=0, `out_valid`=0, `out_width`=0, `out_timeout`=0.
- Trigger: `in_start` high in cycle N → `out_trig` and `out_busy` high in cycles N+1 … N+TRIG_CYCLES.
- Echo measurement: synchronizer latency (2 cycles) is equal on both edges and does not bias the result. With `in_echo` high for exactly E clocks and TICK_DIV=1, `out_width`=E.
- Echo result: `out_valid` asserts 1 cycle after MEASURE exits, i.e. 3 cycles after `in_echo` falls.
- Timeout result: `out_valid` asserts TIMEOUT_CYCLES+1 cycles after the last `out_trig` cycle.
- After the `out_valid` cycle, `out_busy` stays high for HOLDOFF_CYCLES more cycles. The earliest accepted `in_start` is the cycle after.

## Configuration
- `RSENSOR_CTRL_AUTO_EN` defined: free-running mode.
  - HOLDOFF → TRIG directly, without returning to IDLE.
  - The first trigger after reset fires without `in_start` (IDLE → TRIG immediately).
  - `in_start` is ignored.
- Not defined: single-shot operation exactly as described above.

## Test plan
Defaults unless stated: TRIG_CYCLES=10, TIMEOUT_CYCLES=1000, HOLDOFF_CYCLES=50, TICK_DIV=1, CNT_W=16.
- **Reset:** hold `in_rst` for 3 cycles with `in_echo` toggling → all outputs 0; no trigger until `in_start`.
- **Normal measurement:** pulse `in_start` at cycle 0; drive `in_echo` high 30 cycles after trig falls, for 200 cycles → `out_trig` high in cycles 1–10; single `out_valid` pulse; `out_width`=200, `out_timeout`=0.
- **No echo:** pulse `in_start`, no echo → `out_valid` 1001 cycles after last trig cycle; `out_width`=0xFFFF, `out_timeout`=1.
- **Stuck-high echo:** `in_echo` high through trigger and never falls → timeout result as in the no-echo case.
- **Start ignored while busy:** pulse `in_start` during TRIG, MEASURE and HOLDOFF → no extra trigger. Pulse `in_start` on the first IDLE cycle → accepted.
- **Prescaler, saturation and mid-measure reset:**
  - TICK_DIV=4, echo 200 cycles → width 50.
  - CNT_W=4, echo 40 cycles → width 15, `out_timeout`=0.
  - Assert `in_rst` mid-MEASURE → no `out_valid`, `out_width` stays 0.
- **Auto mode (`RSENSOR_CTRL_AUTO_EN`):** three results arrive unprompted; consecutive trigger starts are spaced exactly (trig + wait + measure + 1 + HOLDOFF_CYCLES) cycles apart.
